// File: rtl/led_trail_if.sv
// Pattern-in / PWM-out bundle between the LED chaser
// and the comet-trail PWM stage.
interface led_trail_if #(
  parameter int LED_N = 8
);
  logic             enable;
  logic [LED_N-1:0] pat_in;
  logic [LED_N-1:0] led_out;
  logic             pwm_wrap;

  modport master (
    output enable,
    output pat_in,
    input  led_out,
    input  pwm_wrap
  );

  modport slave (
    input  enable,
    input  pat_in,
    output led_out,
    output pwm_wrap
  );
endinterface

// File: rtl/led_trail_pwm.sv
// Comet-trail LED driver: per-LED brightness set by the
// chaser pattern, decayed on a slow tick, rendered as PWM.
module led_trail_pwm #(
  parameter int LED_N          = 8,
  parameter int PWM_BITS       = 8,
  parameter int DECAY_DIV      = 1000000,
  parameter int DECAY_CNT_BITS = 20,
  parameter int DECAY_STEP     = 16
) (
  input logic         clk,
  input logic         rst_n,
  led_trail_if.slave  bus
);

  localparam logic [PWM_BITS-1:0] MAX  = '1;
  localparam logic [PWM_BITS-1:0] LAST = MAX - 1'b1;
  localparam logic [PWM_BITS-1:0] STEP =
    PWM_BITS'(DECAY_STEP);
  localparam logic [DECAY_CNT_BITS-1:0] DEC_LAST =
    DECAY_CNT_BITS'(DECAY_DIV - 1);

  logic [LED_N-1:0]          pat_q;
  logic [PWM_BITS-1:0]       bri    [LED_N];
  logic [PWM_BITS-1:0]       duty   [LED_N];
  logic [PWM_BITS-1:0]       bri_n  [LED_N];
  logic [PWM_BITS-1:0]       duty_n [LED_N];
  logic [LED_N-1:0]          led_n;
  logic [PWM_BITS-1:0]       pwm_cnt;
  logic [DECAY_CNT_BITS-1:0] dec_cnt;
  logic                      dec_tick;
  logic                      pwm_last;

  assign dec_tick = (dec_cnt == DEC_LAST);
  assign pwm_last = (pwm_cnt == LAST);

  // Set beats decay; decay saturates at zero.
  always_comb begin
    for (int i = 0; i < LED_N; i++) begin
      bri_n[i]  = bri[i];
      duty_n[i] = pwm_last ? bri[i] : duty[i];
      led_n[i]  = bus.enable & (pwm_cnt < duty[i]);
      if (pat_q[i])
        bri_n[i] = MAX;
      else if (dec_tick)
        bri_n[i] = (bri[i] > STEP) ? bri[i] - STEP : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pat_q <= '0;
    else
      pat_q <= bus.pat_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt      <= '0;
      dec_cnt      <= '0;
      bus.led_out  <= '0;
      bus.pwm_wrap <= 1'b0;
      for (int i = 0; i < LED_N; i++) begin
        bri[i]  <= '0;
        duty[i] <= '0;
      end
    end else if (!bus.enable) begin
      pwm_cnt      <= '0;
      dec_cnt      <= '0;
      bus.led_out  <= '0;
      bus.pwm_wrap <= 1'b0;
      for (int i = 0; i < LED_N; i++) begin
        bri[i]  <= '0;
        duty[i] <= '0;
      end
    end else begin
      pwm_cnt      <= pwm_last ? '0 : pwm_cnt + 1'b1;
      dec_cnt      <= dec_tick ? '0 : dec_cnt + 1'b1;
      bus.led_out  <= led_n;
      bus.pwm_wrap <= pwm_last;
      for (int i = 0; i < LED_N; i++) begin
        bri[i]  <= bri_n[i];
        duty[i] <= duty_n[i];
      end
    end
  end

endmodule
